phys_reg_file_mp: RTL and testbench

//  Parametrised multi-port physical register file for the out-of-order core, with an integrated
//  per-register ready bit (busy table) and same-cycle write-to-read bypass. Sits between rename/

---
 rtl/phys_reg_file_mp_if.sv | 33 +++
 rtl/phys_reg_file_mp.sv | 91 +++++++++
 tb/tb_phys_reg_file_mp.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/phys_reg_file_mp_if.sv
// rtl/phys_reg_file_mp_if.sv - write, allocate and operand-read bus of the physical register file
interface phys_reg_file_mp_if #(
    parameter int NUM_PREGS = 64,
    parameter int DATA_W    = 32,
    parameter int NUM_WR    = 2,
    parameter int NUM_RD    = 2,
    parameter int NUM_ALLOC = 2
);
    localparam int PIDX_W = $clog2(NUM_PREGS);

    logic [NUM_WR-1:0]                 wr_en;
    logic [NUM_WR-1:0][PIDX_W-1:0]     wr_idx;
    logic [NUM_WR-1:0][DATA_W-1:0]     wr_data;
    logic [NUM_ALLOC-1:0]              alloc_en;
    logic [NUM_ALLOC-1:0][PIDX_W-1:0]  alloc_idx;
    logic [NUM_RD-1:0][PIDX_W-1:0]     rs1_idx;
    logic [NUM_RD-1:0][PIDX_W-1:0]     rs2_idx;
    logic [NUM_RD-1:0][DATA_W-1:0]     rs1_data;
    logic [NUM_RD-1:0][DATA_W-1:0]     rs2_data;
    logic [NUM_RD-1:0]                 rs1_rdy;
    logic [NUM_RD-1:0]                 rs2_rdy;
    logic                              wr_conflict;

    modport master (
        output wr_en, wr_idx, wr_data, alloc_en, alloc_idx, rs1_idx, rs2_idx,
        input  rs1_data, rs2_data, rs1_rdy, rs2_rdy, wr_conflict
    );

    modport slave (
        input  wr_en, wr_idx, wr_data, alloc_en, alloc_idx, rs1_idx, rs2_idx,
        output rs1_data, rs2_data, rs1_rdy, rs2_rdy, wr_conflict
    );
endinterface

// File: rtl/phys_reg_file_mp.sv
// rtl/phys_reg_file_mp.sv - multi-port physical register file with busy table and write bypass
module phys_reg_file_mp #(
    parameter int NUM_PREGS = 64,
    parameter int DATA_W    = 32,
    parameter int NUM_WR    = 2,
    parameter int NUM_RD    = 2,
    parameter int NUM_ALLOC = 2
) (
    input  logic              clk,
    input  logic              rst,
    phys_reg_file_mp_if.slave rf
);
    localparam int PIDX_W = $clog2(NUM_PREGS);

    logic [DATA_W-1:0]                 data_q [NUM_PREGS];
    logic [NUM_PREGS-1:0]              ready_q;
    logic                              wr_conflict_q;
    logic                              conflict_now;
    logic [NUM_RD-1:0][DATA_W-1:0]     rs1_data_c;
    logic [NUM_RD-1:0][DATA_W-1:0]     rs2_data_c;
    logic [NUM_RD-1:0]                 rs1_rdy_c;
    logic [NUM_RD-1:0]                 rs2_rdy_c;

    // Returns {rdy, data}; later write ports override earlier ones, preg 0 is constant.
    function automatic logic [DATA_W:0] lookup(input logic [PIDX_W-1:0] idx);
        logic [DATA_W:0] res;
        res = {ready_q[idx], data_q[idx]};
        for (int i = 0; i < NUM_WR; i++) begin
            if (rf.wr_en[i] && rf.wr_idx[i] == idx) begin
                res = {1'b1, rf.wr_data[i]};
            end
        end
        if (idx == '0) begin
            res = {1'b1, {DATA_W{1'b0}}};
        end
        return res;
    endfunction

    always_comb begin
        rs1_data_c = '0;
        rs2_data_c = '0;
        rs1_rdy_c  = '0;
        rs2_rdy_c  = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            {rs1_rdy_c[k], rs1_data_c[k]} = lookup(rf.rs1_idx[k]);
            {rs2_rdy_c[k], rs2_data_c[k]} = lookup(rf.rs2_idx[k]);
        end
    end

    always_comb begin
        conflict_now = 1'b0;
        for (int i = 0; i < NUM_WR; i++) begin
            for (int j = i + 1; j < NUM_WR; j++) begin
                if (rf.wr_en[i] && rf.wr_en[j] && rf.wr_idx[i] == rf.wr_idx[j]
                        && rf.wr_idx[i] != '0) begin
                    conflict_now = 1'b1;
                end
            end
        end
    end

    // Allocs are applied after writes so a same-cycle alloc leaves the preg busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p < NUM_PREGS; p++) begin
                data_q[p] <= '0;
            end
            ready_q       <= '1;
            wr_conflict_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_WR; i++) begin
                if (rf.wr_en[i] && rf.wr_idx[i] != '0) begin
                    data_q[rf.wr_idx[i]]  <= rf.wr_data[i];
                    ready_q[rf.wr_idx[i]] <= 1'b1;
                end
            end
            for (int j = 0; j < NUM_ALLOC; j++) begin
                if (rf.alloc_en[j] && rf.alloc_idx[j] != '0) begin
                    ready_q[rf.alloc_idx[j]] <= 1'b0;
                end
            end
            wr_conflict_q <= wr_conflict_q | conflict_now;
        end
    end

    assign rf.rs1_data    = rs1_data_c;
    assign rf.rs2_data    = rs2_data_c;
    assign rf.rs1_rdy     = rs1_rdy_c;
    assign rf.rs2_rdy     = rs2_rdy_c;
    assign rf.wr_conflict = wr_conflict_q;
endmodule

// File: tb/tb_phys_reg_file_mp.sv
// tb/tb_phys_reg_file_mp.sv - randomized self-checking bench for phys_reg_file_mp
module tb_phys_reg_file_mp;
    localparam int NP = 64;
    localparam int DW = 32;
    localparam int NW = 2;
    localparam int NR = 2;
    localparam int NA = 2;
    localparam int PW = $clog2(NP);

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [DW-1:0] m_data [NP];
    logic [NP-1:0] m_ready;
    logic          m_conf;

    phys_reg_file_mp_if #(.NUM_PREGS(NP), .DATA_W(DW), .NUM_WR(NW), .NUM_RD(NR), .NUM_ALLOC(NA)) rf();

    phys_reg_file_mp #(.NUM_PREGS(NP), .DATA_W(DW), .NUM_WR(NW), .NUM_RD(NR), .NUM_ALLOC(NA)) dut (
        .clk (clk),
        .rst (rst),
        .rf  (rf.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW:0] ref_read(input int r);
        logic [DW:0] res;
        if (r == 0) return {1'b1, {DW{1'b0}}};
        res = {m_ready[r], m_data[r]};
        for (int i = 0; i < NW; i++)
            if (rf.wr_en[i] && int'(rf.wr_idx[i]) == r) res = {1'b1, rf.wr_data[i]};
        return res;
    endfunction

    task automatic check_reads(input string tag);
        logic [DW:0] e;
        for (int k = 0; k < NR; k++) begin
            e = ref_read(int'(rf.rs1_idx[k]));
            check({tag, "_rs1_data"}, 64'(rf.rs1_data[k]), 64'(e[DW-1:0]));
            check({tag, "_rs1_rdy"},  64'(rf.rs1_rdy[k]),  64'(e[DW]));
            e = ref_read(int'(rf.rs2_idx[k]));
            check({tag, "_rs2_data"}, 64'(rf.rs2_data[k]), 64'(e[DW-1:0]));
            check({tag, "_rs2_rdy"},  64'(rf.rs2_rdy[k]),  64'(e[DW]));
        end
        check({tag, "_conflict"}, 64'(rf.wr_conflict), 64'(m_conf));
    endtask

    task automatic clear_inputs();
        rf.wr_en = '0; rf.wr_idx = '0; rf.wr_data = '0;
        rf.alloc_en = '0; rf.alloc_idx = '0;
        rf.rs1_idx = '0; rf.rs2_idx = '0;
    endtask

    task automatic tick();
        if (rst) begin
            for (int p = 0; p < NP; p++) m_data[p] = '0;
            m_ready = '1;
            m_conf  = 1'b0;
        end else begin
            for (int i = 0; i < NW; i++) begin
                for (int j = i + 1; j < NW; j++)
                    if (rf.wr_en[i] && rf.wr_en[j] && rf.wr_idx[i] == rf.wr_idx[j] && rf.wr_idx[i] != 0)
                        m_conf = 1'b1;
                if (rf.wr_en[i] && rf.wr_idx[i] != 0) begin
                    m_data[rf.wr_idx[i]]  = rf.wr_data[i];
                    m_ready[rf.wr_idx[i]] = 1'b1;
                end
            end
            for (int j = 0; j < NA; j++)
                if (rf.alloc_en[j] && rf.alloc_idx[j] != 0) m_ready[rf.alloc_idx[j]] = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [PW-1:0] rand_idx();
        if ($urandom_range(0, 2) == 0) return PW'($urandom_range(0, 3));
        return PW'($urandom_range(0, NP - 1));
    endfunction

    initial begin
        rst = 1'b0;
        clear_inputs();
        do_reset();

        for (int r = 0; r < NP; r++) begin
            for (int k = 0; k < NR; k++) begin
                rf.rs1_idx[k] = PW'(r);
                rf.rs2_idx[k] = PW'(r);
            end
            #1;
            check_reads("t1_reset_read");
        end
        check("t1_conflict", 64'(rf.wr_conflict), 64'd0);

        clear_inputs();
        rf.alloc_en[0] = 1'b1; rf.alloc_idx[0] = PW'(5); rf.rs1_idx[0] = PW'(5);
        #1;
        check("t2_alloc_same_cycle_rdy", 64'(rf.rs1_rdy[0]), 64'd1);
        tick();
        clear_inputs();
        rf.rs1_idx[0] = PW'(5);
        #1;
        check("t2_alloc_rdy", 64'(rf.rs1_rdy[0]), 64'd0);
        rf.wr_en[1] = 1'b1; rf.wr_idx[1] = PW'(5); rf.wr_data[1] = 32'hDEAD_BEEF;
        #1;
        check("t2_bypass_data", 64'(rf.rs1_data[0]), 64'hDEAD_BEEF);
        check("t2_bypass_rdy", 64'(rf.rs1_rdy[0]), 64'd1);
        tick();
        clear_inputs();
        rf.rs1_idx[0] = PW'(5);
        #1;
        check("t2_array_data", 64'(rf.rs1_data[0]), 64'hDEAD_BEEF);
        check("t2_array_rdy", 64'(rf.rs1_rdy[0]), 64'd1);

        clear_inputs();
        rf.wr_en = '1; rf.wr_idx[0] = PW'(9); rf.wr_idx[1] = PW'(9);
        rf.wr_data[0] = 32'd11; rf.wr_data[1] = 32'd22; rf.rs2_idx[1] = PW'(9);
        #1;
        check("t3_bypass_data", 64'(rf.rs2_data[1]), 64'd22);
        tick();
        clear_inputs();
        rf.rs2_idx[1] = PW'(9);
        #1;
        check("t3_array_data", 64'(rf.rs2_data[1]), 64'd22);
        check("t3_conflict_set", 64'(rf.wr_conflict), 64'd1);
        tick();
        check("t3_conflict_sticky", 64'(rf.wr_conflict), 64'd1);

        do_reset();
        rf.wr_en = '1; rf.wr_idx = '0; rf.wr_data[0] = 32'h1234; rf.wr_data[1] = 32'h1234;
        rf.alloc_en[0] = 1'b1; rf.alloc_idx[0] = '0;
        #1;
        check("t4_zero_data_now", 64'(rf.rs1_data[0]), 64'd0);
        tick();
        clear_inputs();
        #1;
        check("t4_zero_data", 64'(rf.rs1_data[0]), 64'd0);
        check("t4_zero_rdy", 64'(rf.rs1_rdy[0]), 64'd1);
        check("t4_no_conflict", 64'(rf.wr_conflict), 64'd0);

        rf.alloc_en[1] = 1'b1; rf.alloc_idx[1] = PW'(12);
        rf.wr_en[0] = 1'b1; rf.wr_idx[0] = PW'(12); rf.wr_data[0] = 32'd7;
        tick();
        clear_inputs();
        rf.rs1_idx[1] = PW'(12);
        #1;
        check("t5_data", 64'(rf.rs1_data[1]), 64'd7);
        check("t5_rdy", 64'(rf.rs1_rdy[1]), 64'd0);

        rf.wr_en[0] = 1'b1; rf.wr_idx[0] = PW'(63); rf.wr_data[0] = 32'd5;
        tick();
        rf.wr_data[0] = 32'd6;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        clear_inputs();
        rf.rs1_idx[0] = PW'(63);
        #1;
        check("t6_data", 64'(rf.rs1_data[0]), 64'd0);
        check("t6_rdy", 64'(rf.rs1_rdy[0]), 64'd1);

        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NW; i++) begin
                rf.wr_en[i]   = 1'($urandom_range(0, 1));
                rf.wr_idx[i]  = rand_idx();
                rf.wr_data[i] = DW'($urandom);
            end
            for (int j = 0; j < NA; j++) begin
                rf.alloc_en[j]  = ($urandom_range(0, 2) == 0);
                rf.alloc_idx[j] = rand_idx();
            end
            for (int k = 0; k < NR; k++) begin
                rf.rs1_idx[k] = rand_idx();
                rf.rs2_idx[k] = rand_idx();
            end
            rst = ($urandom_range(0, 99) == 0);
            #1;
            check_reads("rand");
            tick();
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
